// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the HD44780-style LCD sequencer: register fields, FSM states,
// command codes and the power-on init ROM.
package lcd_ctrl_pkg;

  localparam int unsigned LcdOnBit  = 31;
  localparam int unsigned LcdGoBit  = 30;
  localparam int unsigned LcdRsBit  = 9;
  localparam int unsigned InitLen   = 6;

  localparam logic [7:0] CmdClear = 8'h01;
  localparam logic [7:0] CmdHome  = 8'h02;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StExec,
    StPwrup,
    StInit
  } lcd_state_e;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    logic [7:0] val;
    case (idx)
      3'd0, 3'd1, 3'd2: val = 8'h38;
      3'd3:             val = 8'h0C;
      3'd4:             val = CmdClear;
      3'd5:             val = 8'h06;
      default:          val = 8'h00;
    endcase
    return val;
  endfunction

  // Clear, home (and 0x03, which the panel also decodes as home) need the long wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CmdClear || data == CmdHome || data == 8'h03);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed LCD state; done while the count is zero.
module lcd_timer #(
  parameter int unsigned       Width  = 8,
  parameter logic [Width-1:0]  RstVal = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RstVal;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Character LCD byte-write sequencer driven by a GO edge in the LSU LCD register.
// Define LCD_INIT_SEQ_EN to run the power-up wait and ROM init sequence after reset.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned T_AS        = 2,
  parameter int unsigned T_PW        = 12,
  parameter int unsigned T_H         = 1,
  parameter int unsigned T_EXEC      = 1850,
  parameter int unsigned T_EXEC_LONG = 76000,
  parameter int unsigned T_PWRUP     = 750000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lcd_reg_i,
  output logic        busy_o,
  output logic        ovf_o,
  output logic        lcd_on_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic [7:0]  lcd_data_o
);

  localparam int unsigned MaxT = max_u(max_u(max_u(T_AS, T_PW), max_u(T_H, T_EXEC)),
                                       max_u(T_EXEC_LONG, T_PWRUP));
  localparam int unsigned CntW = (MaxT > 1) ? $clog2(MaxT) : 1;

  // Timer loads N-1 so each state lasts exactly N cycles.
  localparam logic [CntW-1:0] LdAs       = CntW'(T_AS - 1);
  localparam logic [CntW-1:0] LdPw       = CntW'(T_PW - 1);
  localparam logic [CntW-1:0] LdH        = CntW'(T_H - 1);
  localparam logic [CntW-1:0] LdExec     = CntW'(T_EXEC - 1);
  localparam logic [CntW-1:0] LdExecLong = CntW'(T_EXEC_LONG - 1);

`ifdef LCD_INIT_SEQ_EN
  localparam lcd_state_e      RstState = StPwrup;
  localparam logic            RstBusy  = 1'b1;
  localparam logic [CntW-1:0] TimerRst = CntW'(T_PWRUP - 1);
`else
  localparam lcd_state_e      RstState = StIdle;
  localparam logic            RstBusy  = 1'b0;
  localparam logic [CntW-1:0] TimerRst = '0;
`endif

  lcd_state_e      state_q, state_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            ovf_q, ovf_d;
  logic            go_q, on_q, busy_q, en_q;
  logic            go_edge, tmr_load, tmr_done;
  logic [CntW-1:0] tmr_val;
  logic            unused_reg;

`ifdef LCD_INIT_SEQ_EN
  logic       init_q, init_d;
  logic [2:0] idx_q, idx_d;
`endif

  assign go_edge    = lcd_reg_i[LcdGoBit] & ~go_q;
  assign unused_reg = ^{lcd_reg_i[29:10], lcd_reg_i[8]};

  lcd_timer #(
    .Width  (CntW),
    .RstVal (TimerRst)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef LCD_INIT_SEQ_EN
    init_d   = init_q;
    idx_d    = idx_q;
`endif
    case (state_q)
      StIdle: begin
        if (go_edge) begin
          rs_d     = lcd_reg_i[LcdRsBit];
          data_d   = lcd_reg_i[7:0];
          state_d  = StSetup;
          tmr_load = 1'b1;
          tmr_val  = LdAs;
        end
      end
      StSetup: begin
        if (tmr_done) begin
          state_d  = StPulse;
          tmr_load = 1'b1;
          tmr_val  = LdPw;
        end
      end
      StPulse: begin
        if (tmr_done) begin
          state_d  = StHold;
          tmr_load = 1'b1;
          tmr_val  = LdH;
        end
      end
      StHold: begin
        if (tmr_done) begin
          state_d  = StExec;
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(rs_q, data_q) ? LdExecLong : LdExec;
        end
      end
      StExec: begin
        if (tmr_done) begin
          state_d = StIdle;
`ifdef LCD_INIT_SEQ_EN
          if (init_q) begin
            if (idx_q == 3'(InitLen - 1)) begin
              init_d = 1'b0;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = StInit;
            end
          end
`endif
        end
      end
`ifdef LCD_INIT_SEQ_EN
      StPwrup: begin
        if (tmr_done) state_d = StInit;
      end
      StInit: begin
        rs_d     = 1'b0;
        data_d   = init_rom(idx_q);
        state_d  = StSetup;
        tmr_load = 1'b1;
        tmr_val  = LdAs;
      end
`endif
      default: state_d = StIdle;
    endcase
    if (go_edge && state_q != StIdle) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RstState;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      ovf_q   <= 1'b0;
      go_q    <= 1'b0;
      on_q    <= 1'b0;
      busy_q  <= RstBusy;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      go_q    <= lcd_reg_i[LcdGoBit];
      on_q    <= lcd_reg_i[LcdOnBit];
      busy_q  <= (state_d != StIdle);
      en_q    <= (state_d == StPulse);
    end
  end

`ifdef LCD_INIT_SEQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b1;
      idx_q  <= 3'd0;
    end else begin
      init_q <= init_d;
      idx_q  <= idx_d;
    end
  end
`endif

  assign busy_o     = busy_q;
  assign ovf_o      = ovf_q;
  assign lcd_on_o   = on_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = en_q;
  assign lcd_data_o = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: cycle model of the write protocol plus directed vectors.
module tb_lcd_ctrl;

  localparam int unsigned TAs = 2, TPw = 3, TH = 1, TExec = 5, TExecLong = 20, TPwrup = 10;
`ifdef LCD_INIT_SEQ_EN
  localparam logic InitEn = 1'b1;
`else
  localparam logic InitEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] lcd_reg = '0;
  logic        busy, ovf, lcd_on, lcd_rs, lcd_rw, lcd_en;
  logic [7:0]  lcd_data;

  lcd_ctrl #(
    .T_AS        (TAs),
    .T_PW        (TPw),
    .T_H         (TH),
    .T_EXEC      (TExec),
    .T_EXEC_LONG (TExecLong),
    .T_PWRUP     (TPwrup)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_reg_i  (lcd_reg),
    .busy_o     (busy),
    .ovf_o      (ovf),
    .lcd_on_o   (lcd_on),
    .lcd_rs_o   (lcd_rs),
    .lcd_rw_o   (lcd_rw),
    .lcd_en_o   (lcd_en),
    .lcd_data_o (lcd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: a transfer is "active" for a fixed number of cycles counted from the GO edge.
  logic       m_go_prev, m_active, m_rs, m_ovf, m_on;
  logic [7:0] m_data;
  int         m_t, m_total;
  logic       cmp_en = 1'b0;

  initial begin : model
    logic edge_m, was_active;
    m_go_prev = 0; m_active = 0; m_rs = 0; m_ovf = 0; m_on = 0; m_data = 0; m_t = 0; m_total = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_go_prev = 0; m_active = 0; m_rs = 0; m_ovf = 0; m_on = 0; m_data = 0; m_t = 0;
      end else begin
        edge_m     = lcd_reg[30] & ~m_go_prev;
        m_go_prev  = lcd_reg[30];
        m_on       = lcd_reg[31];
        was_active = m_active;
        if (m_active) begin
          m_t++;
          if (m_t == m_total) m_active = 0;
        end
        if (edge_m) begin
          if (was_active) m_ovf = 1;
          else begin
            m_active = 1;
            m_t      = 0;
            m_rs     = lcd_reg[9];
            m_data   = lcd_reg[7:0];
            m_total  = TAs + TPw + TH +
                       ((!m_rs && m_data >= 8'h01 && m_data <= 8'h03) ? TExecLong : TExec);
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n && cmp_en) begin
        check("busy", busy, m_active);
        check("lcd_en", lcd_en, m_active && m_t >= TAs && m_t < TAs + TPw);
        check("lcd_rs", lcd_rs, m_rs);
        check("lcd_data", lcd_data, m_data);
        check("ovf", ovf, m_ovf);
        check("lcd_on", lcd_on, m_on);
        check("lcd_rw", lcd_rw, 1'b0);
      end
    end
  end

  task automatic run_xfer(input logic [31:0] val, output int busy_n, output int en_n,
                          output int en_off, output int pulses);
    int   first;
    logic prev_en, done;
    @(negedge clk);
    lcd_reg = val;
    busy_n = 0; en_n = 0; en_off = -1; pulses = 0; first = -1; prev_en = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (busy) begin
        if (first < 0) first = i;
        busy_n++;
      end
      if (lcd_en) begin
        en_n++;
        if (en_off < 0) en_off = i - first;
      end
      if (lcd_en && !prev_en) pulses++;
      prev_en = lcd_en;
      if (first >= 0 && !busy) done = 1;
    end
    if (!done) check("xfer_timeout", 0, 1);
    lcd_reg = val & ~32'h4000_0000;
    @(negedge clk);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    logic prev_en;
    prev_en = 0; pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (lcd_en && !prev_en) pulses++;
      prev_en = lcd_en;
    end
  endtask

  logic [31:0] vec_reg  [7] = '{32'h4000_0241, 32'h4000_0001, 32'h4000_0000, 32'h4000_0002,
                                32'h4000_0003, 32'h4000_0004, 32'h4000_0201};
  int          vec_busy [7] = '{11, 26, 11, 26, 26, 11, 11};

  initial begin : main
    int b, e, o, p;
    #12;
    check("rst_busy", busy, InitEn);
    check("rst_ovf", ovf, 0);
    check("rst_on", lcd_on, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_en", lcd_en, 0);
    check("rst_data", lcd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef LCD_INIT_SEQ_EN
    begin : init_seq
      logic [7:0] exp_init [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      logic [7:0] got [$];
      logic       prev_en, seen_clear, done;
      int         fall_i, first_rise;
      prev_en = 0; seen_clear = 0; done = 0; fall_i = 0; first_rise = -1;
      #1 check("init_busy_after_rst", busy, 1);
      for (int i = 0; i < 2000 && !done; i++) begin
        @(negedge clk);
        if (lcd_en && !prev_en) begin
          if (first_rise < 0) first_rise = i;
          if (seen_clear) begin
            check("init_clear_wait", (i - fall_i) >= (TH + TExecLong), 1);
            seen_clear = 0;
          end
          got.push_back(lcd_data);
          check("init_rs", lcd_rs, 0);
          check("init_busy", busy, 1);
        end
        if (!lcd_en && prev_en) begin
          fall_i = i;
          if (lcd_data == 8'h01) seen_clear = 1;
        end
        prev_en = lcd_en;
        if (!busy) done = 1;
      end
      check("init_done", done, 1);
      check("init_pwrup", first_rise >= int'(TPwrup), 1);
      check("init_count", got.size(), 6);
      for (int k = 0; k < 6 && k < got.size(); k++) check("init_byte", got[k], exp_init[k]);
      m_data = 8'h06;
      m_rs   = 1'b0;
    end
`endif
    cmp_en = 1'b1;

    // Data write plus long/short command boundaries.
    for (int k = 0; k < 7; k++) begin
      run_xfer(vec_reg[k], b, e, o, p);
      check("xfer_busy_len", b, vec_busy[k]);
      check("xfer_en_len", e, TPw);
      check("xfer_en_off", o, TAs);
      check("xfer_pulses", p, 1);
    end

    @(negedge clk) lcd_reg = 32'h8000_0000;
    @(negedge clk) check("lcd_on_set", lcd_on, 1);

    // Overrun: new GO edge 4 cycles into a transfer is dropped.
    check("ovf_before", ovf, 0);
    @(negedge clk) lcd_reg = 32'h4000_0241;
    @(negedge clk) lcd_reg = 32'h0000_0255;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk) lcd_reg = 32'h4000_0255;
    count_pulses(20, p);
    check("ovr_pulses", p, 1);
    check("ovr_ovf", ovf, 1);
    check("ovr_data", lcd_data, 8'h41);
    lcd_reg = 32'h0;
    count_pulses(5, p);
    check("ovr_sticky", ovf, 1);

    // Held GO triggers once; clear and re-set triggers again.
    lcd_reg = 32'h4000_0242;
    count_pulses(50, p);
    check("held_pulses", p, 1);
    lcd_reg = 32'h0;
    @(negedge clk) lcd_reg = 32'h4000_0242;
    count_pulses(30, p);
    check("reset_go_pulses", p, 1);
    lcd_reg = 32'h0;
    @(negedge clk);

    // Asynchronous reset in the middle of the E pulse.
    lcd_reg = 32'h4000_0243;
    begin : wait_en
      logic seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (lcd_en) seen = 1;
      end
      check("pulse_seen", seen, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_en", lcd_en, 0);
    check("arst_busy", busy, InitEn);
    check("arst_ovf", ovf, 0);
    check("arst_on", lcd_on, 0);
    check("arst_rs", lcd_rs, 0);
    check("arst_data", lcd_data, 0);
    cmp_en = 1'b0;
    lcd_reg = 32'h0;
    @(negedge clk) rst_n = 1'b1;
    count_pulses(3, p);
    check("arst_no_pulse", p, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Hardware HD44780-style character LCD sequencer on the CPU's memory-mapped LCD register output.
- Replaces software bit-banging: a rising edge of a GO bit in the register triggers one byte write with correct E-pulse timing.
- Exposes a busy flag, wired back to an LSU input port, so software can poll completion.
- Sits directly downstream of the LSU LCD register in the pipelined CPU top; drives the board LCD pins.

Parameters:
- T_AS, 2: cycles RS/data setup before E rises.
- T_PW, 12: cycles E held high (≥230 ns at 50 MHz).
- T_H, 1: cycles RS/data held after E falls.
- T_EXEC, 1850: cycles wait after a normal command/data write (37 µs).
- T_EXEC_LONG, 76000: cycles wait after clear/home (1.52 ms).
- T_PWRUP, 750000: cycles power-up wait before init (15 ms); used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lcd_reg  in  32  LSU LCD register: [31]=ON, [30]=GO, [9]=RS, [7:0]=DATA; other bits ignored
- busy  out  1  high while a write or init is in progress
- ovf  out  1  sticky: a GO edge was dropped while busy
- lcd_on  out  1  LCD power/backlight enable
- lcd_rs  out  1  register select
- lcd_rw  out  1  read/write select; constant 0
- lcd_en  out  1  enable strobe
- lcd_data  out  8  data bus

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: busy=0 (1 if LCD_INIT_SEQ_EN), ovf=0, lcd_on=0, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data=0x00, state=IDLE (PWRUP with the feature), go_q=0.
- lcd_on: lcd_reg[31] registered, one cycle latency; independent of the FSM.
- GO detection: go_q <= lcd_reg[30]; an edge is lcd_reg[30] & ~go_q.
- GO edge in IDLE: latch RS=lcd_reg[9] and DATA=lcd_reg[7:0] onto lcd_rs/lcd_data; busy=1 in the same clock edge; enter SETUP.
- GO edge in any other state: request is dropped, ovf <= 1 (sticky until reset), no effect on the current transfer.
- A level-held GO does not retrigger; software must clear and re-set the bit.
- FSM states and transitions; a single down-counter cnt (width clog2 of the largest parameter) is loaded on entry to each state:
  - SETUP: T_AS cycles, lcd_en=0 → PULSE.
  - PULSE: T_PW cycles, lcd_en=1 → HOLD.
  - HOLD: T_H cycles, lcd_en=0 → EXEC.
  - EXEC: T_EXEC_LONG if RS=0 and DATA∈{0x01,0x02,0x03}, else T_EXEC → IDLE; busy=0 on the IDLE cycle.
- Total busy time for a normal write: T_AS+T_PW+T_H+T_EXEC cycles, exact.
- lcd_rs and lcd_data are stable from SETUP entry through the end of HOLD; they keep the last value in IDLE.
- Zero-valued timing parameters are illegal; the minimum is 1.
- Asynchronous reset mid-transfer: lcd_en drops low immediately and the FSM returns to its reset state; no partial pulse is completed.
- lcd_en is always a registered output; no glitches.

Optional Feature:
- Macro: LCD_INIT_SEQ_EN.
- Defined:
  - After reset, the FSM enters PWRUP for T_PWRUP cycles, then INIT.
  - INIT sends the ROM sequence 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, all RS=0, using SETUP/PULSE/HOLD/EXEC with normal long/short rules.
  - A 3-bit init index advances after each EXEC; after the 6th byte the FSM goes to IDLE.
  - busy=1 throughout.
  - GO edges during init set ovf.
- Undefined: the FSM starts in IDLE, busy=0 after reset, and software performs its own initialisation.

Decomposition:
- Shared package/header (alongside cpu_def.vh):
  - LCD register bit positions: LCD_ON_BIT=31, LCD_GO_BIT=30, LCD_RS_BIT=9, DATA field [7:0].
  - FSM state encodings: IDLE, SETUP, PULSE, HOLD, EXEC, PWRUP, INIT.
  - Init ROM contents and length (6).
  - Command codes CLEAR=0x01 and HOME=0x02.
- Sub-module lcd_timer: a loadable down-counter with a done flag. It is the natural single child, reused by every timed state.

Test Plan (bench overrides T_AS=2, T_PW=3, T_H=1, T_EXEC=5, T_EXEC_LONG=20, T_PWRUP=10):
- Data write: lcd_reg=0x4000_0241 (GO, RS=1, 'A') from idle → busy rises next edge; lcd_en high for exactly 3 cycles starting 2 cycles after busy; lcd_rs=1, lcd_data=0x41 throughout; busy falls 11 cycles after it rose.
- Clear: lcd_reg=0x4000_0001 → EXEC lasts 20 cycles; total busy 26 cycles. Repeat with 0x4000_0000 → total busy 11 cycles.
- Overrun: toggle GO again 4 cycles into a transfer → ovf=1 and stays 1; the in-flight lcd_data is unchanged; no second E pulse.
- Held GO: keep bit 30 high for 50 cycles → exactly one E pulse; clear then set GO → a second pulse.
- Reset during PULSE: assert rst_n=0 mid-pulse → lcd_en=0 within the same cycle without a clock edge; all outputs at their reset values.
- With LCD_INIT_SEQ_EN: release reset → busy=1; after 10 cycles, 6 E pulses with data 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 and RS=0; the 0x01 pulse is followed by a 20-cycle wait; then busy=0.
